// File: rtl/uart_rx_stream.sv
// uart_rx_stream: oversampling UART receiver with an output FIFO.
// Frame: start + DATA_BITS (LSB first) [+ parity] + stop.
// Optional parity support is compiled in with the macro UART_RX_PARITY_EN,
// which also adds the PARITY_ODD parameter.
// Handshake: rx_valid is high while the FIFO holds an entry; the head entry
// (rx_data/rx_frame_err/rx_parity_err) is consumed in any cycle where
// rx_valid & rx_ready, and is held stable while rx_valid & !rx_ready.
module uart_rx_stream #(
  parameter int CLKS_PER_BIT = 186,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int SYNC_STAGES  = 2
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_port_DI,
  input  logic                          rx_ready,
  input  logic                          clear_ovf,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = DATA_BITS + 2;  // {parity_err, frame_err, data}
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [AW:0]   DEPTH    = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
    , S_PARITY = 3'd5
`endif
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   push;
  logic                   push_pe;
  logic [WW-1:0]          push_word;

  logic [WW-1:0]          mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]            count_q, count_d;
  logic [WW-1:0]          head_q, head_d;
  logic                   ovf_q, ovf_d;
  logic                   pop, push_ok;

  // Input synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], uart_port_DI};
  end
  assign rxs = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  // Sampled parity bit of the frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end
  assign push_pe = par_q != (^shift_q ^ PARITY_ODD);
`else
  assign push_pe = 1'b0;
`endif

  assign push_word = {push_pe, ~rxs, shift_q};

  // Receiver FSM state and bit-timing registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic; the counter restarts on every state entry and sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    push    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxs ? S_IDLE : S_DATA;  // high at mid-start = glitch
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_q == BIT_LAST) state_d = S_PARITY;
`else
          if (bit_q == BIT_LAST) state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          par_d   = rxs;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // Resync at mid-stop so a following start bit is not missed.
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          push    = 1'b1;
          state_d = rxs ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rxs) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= push_word;
  end

  // FIFO control and registered head-of-queue outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      head_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      head_q  <= head_d;
      ovf_q   <= ovf_d;
    end
  end

  // Push/pop bookkeeping; the head register is loaded with next cycle's head.
  always_comb begin
    pop     = (count_q != '0) && rx_ready;
    push_ok = push && ((count_q < DEPTH) || pop);
    wptr_d  = push_ok ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
    ovf_d = ovf_q;
    if (push && !push_ok) ovf_d = 1'b1;
    else if (clear_ovf)   ovf_d = 1'b0;
    head_d = head_q;
    if (count_d != '0) begin
      // Head equals the word written this cycle only when it becomes the sole entry.
      if (push_ok && (rptr_d == wptr_q)) head_d = push_word;
      else                               head_d = mem_q[rptr_d];
    end
  end

  assign rx_valid      = (count_q != '0);
  assign fifo_count    = count_q;
  assign overflow      = ovf_q;
  assign rx_data       = head_q[DATA_BITS-1:0];
  assign rx_frame_err  = head_q[DATA_BITS];
  assign rx_parity_err = head_q[DATA_BITS+1];

endmodule
